// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Multi-cycle multiply/divide engine for the EX stage (MULT/MULTU/DIV/DIVU).
//   EX raises start_i and holds the op while stall_req_o is high. The result
//   appears as a {hi,lo} pair together with a one-cycle valid_o/whilo_o pulse.
//
// Parameters
//   WIDTH        operand width; hi_o/lo_o are WIDTH bits each
//   MUL_STAGES   busy cycles for a multiply (>= 1)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high, dominates all inputs
//   start_i      op request from EX, held while stalled
//   op_i         0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
//   opa_i/opb_i  rs/rt values, sampled only in the IDLE accept cycle
//   hi_i/lo_i    forwarded HI/LO accumulator source (MADD family only)
//   annul_i      abandon the current op (flush/exception)
//   stall_req_o  pipeline stall request
//   valid_o      one-cycle result pulse; whilo_o mirrors it
//   hi_o/lo_o    mul: {hi,lo} = product; div: lo = quotient, hi = remainder
//   div_zero_o   divisor was zero (qualified by valid_o)
//
// Configuration
//   MULDIV_MADD_EN  defined: ops 4-7 accumulate into {hi_i,lo_i} sampled at
//                   accept. Undefined: ops 4-7 run as MULT (4,6) / MULTU (5,7).

module ex_muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             annul_i,
  output logic             stall_req_o,
  output logic             valid_o,
  output logic             whilo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   quo_q, rem_q, dvs_q;
  logic               neg_q, neg_r;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               dz_q;

  // Op decode on the request (accept cycle) and on the latched op.
  logic req_div, req_sgn, accept, req_dz;
  logic is_div, is_sgn, last_busy;

  assign req_div   = (op_i[2:1] == 2'b01);
  assign req_sgn   = ~op_i[0];
  assign accept    = (state == IDLE) && start_i && !annul_i;
  assign req_dz    = req_div && (opb_i == '0);
  assign is_div    = (op_q[2:1] == 2'b01);
  assign is_sgn    = ~op_q[0];
  assign last_busy = (state == BUSY) && !annul_i && (cnt == CW'(1));

  // Multiply datapath on the latched operands; the busy cycles only model latency.
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;

  assign ext_a = {{WIDTH{is_sgn & a_q[WIDTH-1]}}, a_q};
  assign ext_b = {{WIDTH{is_sgn & b_q[WIDTH-1]}}, b_q};
  assign prod  = ext_a * ext_b;

`ifdef MULDIV_MADD_EN
  logic [2*WIDTH-1:0] acc_q;

  always_comb begin
    mul_res = prod;
    if (op_q[2]) begin
      mul_res = op_q[1] ? (acc_q - prod) : (acc_q + prod);
    end
  end
`else
  logic unused_acc;

  assign unused_acc = ^{hi_i, lo_i};
  assign mul_res    = prod;
`endif

  // One restoring-division step on magnitudes. rem_q < dvs_q always holds, so
  // bit WIDTH of the trial difference is exactly the borrow.
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] step_rem, step_quo, div_lo, div_hi;

  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_q};
    step_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    div_lo   = neg_q ? -step_quo : step_quo;
    div_hi   = neg_r ? -step_rem : step_rem;
  end

  // Next state.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = req_dz ? DONE : BUSY;
      BUSY: begin
        if (annul_i)              state_next = IDLE;
        else if (cnt == CW'(1))   state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
      dz_q   <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_q  <= '0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        op_q  <= op_i;
        a_q   <= opa_i;
        b_q   <= opb_i;
        cnt   <= req_div ? CW'(WIDTH) : CW'(MUL_STAGES);
        rem_q <= '0;
        quo_q <= (req_sgn && opa_i[WIDTH-1]) ? -opa_i : opa_i;
        dvs_q <= (req_sgn && opb_i[WIDTH-1]) ? -opb_i : opb_i;
        neg_q <= req_sgn && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
        neg_r <= req_sgn && opa_i[WIDTH-1];
        dz_q  <= req_dz;
        // Divide by zero resolves at accept and goes straight to DONE.
        if (req_dz) begin
          res_hi <= opa_i;
          res_lo <= '1;
        end
`ifdef MULDIV_MADD_EN
        acc_q <= {hi_i, lo_i};
`endif
      end else if (state == BUSY) begin
        cnt <= cnt - CW'(1);
        if (is_div) begin
          rem_q <= step_rem;
          quo_q <= step_quo;
        end
        if (last_busy) begin
          if (is_div) begin
            res_hi <= div_hi;
            res_lo <= div_lo;
          end else begin
            {res_hi, res_lo} <= mul_res;
          end
        end
      end
    end
  end

  // Outputs: the result is visible only during the valid pulse.
  always_comb begin
    stall_req_o = 1'b0;
    valid_o     = 1'b0;
    if (!rst) begin
      stall_req_o = accept || ((state == BUSY) && !annul_i);
      valid_o     = (state == DONE) && !annul_i;
    end
    whilo_o    = valid_o;
    hi_o       = valid_o ? res_hi : '0;
    lo_o       = valid_o ? res_lo : '0;
    div_zero_o = valid_o && dz_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  localparam int WIDTH      = 32;
  localparam int MUL_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [2:0]        op_i;
  logic [WIDTH-1:0]  opa_i, opb_i, hi_i, lo_i;
  logic              annul_i;
  logic              stall_req_o, valid_o, whilo_o, div_zero_o;
  logic [WIDTH-1:0]  hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(WIDTH), .MUL_STAGES(MUL_STAGES)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .opa_i       (opa_i),
    .opb_i       (opb_i),
    .hi_i        (hi_i),
    .lo_i        (lo_i),
    .annul_i     (annul_i),
    .stall_req_o (stall_req_o),
    .valid_o     (valid_o),
    .whilo_o     (whilo_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .div_zero_o  (div_zero_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hin, lin;
    logic [31:0] ehi, elo;
    logic        edz;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the architectural meaning of each op.
  function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a, b, h, l);
    logic [63:0] p;
    longint      q, r;
    if (op == 3'd2 || op == 3'd3) begin
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      if (op == 3'd2) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        return {1'b0, r[31:0], q[31:0]};
      end
      return {1'b0, a % b, a / b};
    end
    if (!op[0]) p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else        p = {32'd0, a} * {32'd0, b};
`ifdef MULDIV_MADD_EN
    if (op[2]) p = op[1] ? ({h, l} - p) : ({h, l} + p);
`endif
    return {1'b0, p};
  endfunction

  function automatic int unsigned exp_stalls(input logic [2:0] op, input logic [31:0] b);
    if (op == 3'd2 || op == 3'd3) return (b == 32'd0) ? 1 : WIDTH + 1;
    return MUL_STAGES + 1;
  endfunction

  // Issue one op, hold start until the pulse, scramble operand inputs after
  // accept, and check latency, result and the single-cycle pulse.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, h, l,
                        input logic [31:0] ehi, elo, input logic edz, input string tag);
    int unsigned stalls = 0;
    int unsigned guard  = 0;
    bit          seen   = 0;
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b; hi_i = h; lo_i = l;
    while (!seen && guard < 200) begin
      @(negedge clk);
      if (valid_o) seen = 1;
      else begin
        if (stall_req_o) stalls++;
        @(posedge clk); #1;
        opa_i = $urandom; opb_i = $urandom; hi_i = $urandom; lo_i = $urandom;
        guard++;
      end
    end
    chk({tag, "_valid_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls(op, b)));
      chk({tag, "_hi"}, 64'(hi_o), 64'(ehi));
      chk({tag, "_lo"}, 64'(lo_o), 64'(elo));
      chk({tag, "_dz"}, 64'(div_zero_o), 64'(edz));
      chk({tag, "_whilo"}, 64'(whilo_o), 64'd1);
      chk({tag, "_stall_done"}, 64'(stall_req_o), 64'd0);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse_end"}, {62'd0, valid_o, stall_req_o}, 64'd0);
  endtask

  task automatic count_valids(input int unsigned n, output int unsigned cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (valid_o || whilo_o) cnt++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'(int'($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [64:0]  e;
    logic [2:0]   rop;
    logic [31:0]  ra, rb, rh, rl;
    int unsigned  nv;

    vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mult_m1x2"});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, "multu_x2"});
    vecs.push_back('{3'd3, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 1'b0, "divu_100_7"});
    vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7_2"});
    vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 1'b0, "div_min_m1"});
    vecs.push_back('{3'd3, 32'd5, 32'd0, 32'h0, 32'h0, 32'd5, 32'hFFFF_FFFF, 1'b1, "divu_by0"});
    vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'd0, 32'h0, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div_by0"});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max"});
    vecs.push_back('{3'd2, 32'd7, 32'hFFFF_FFFE, 32'h0, 32'h0, 32'd1, 32'hFFFF_FFFD, 1'b0, "div_7_m2"});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 32'd0, 32'hFFFF_FFFF, 1'b0, "divu_max_1"});
`ifdef MULDIV_MADD_EN
    vecs.push_back('{3'd5, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "maddu_carry"});
    vecs.push_back('{3'd6, 32'd1, 32'd1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "msub_from0"});
`else
    vecs.push_back('{3'd4, 32'hFFFF_FFFF, 32'h2, 32'h1234_5678, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "op4_as_mult"});
    vecs.push_back('{3'd7, 32'd3, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd12, 1'b0, "op7_as_multu"});
`endif

    // Reset dominates a pending start.
    rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; op_i = 3'd2;
    opa_i = 32'd9; opb_i = 32'd0; hi_i = '0; lo_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {stall_req_o, valid_o, whilo_o, div_zero_o, hi_o, lo_o}, 68'd0);
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", {58'd0, stall_req_o, valid_o, whilo_o}, 64'd0);

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hin, vecs[i].lin,
             vecs[i].ehi, vecs[i].elo, vecs[i].edz, vecs[i].tag);

    // Annul at BUSY cycle 10 of a DIV, then a MULTU must still work.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'd2; opa_i = 32'd1000; opb_i = 32'd3;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 annul_i = 1'b1;
    @(negedge clk);
    chk("annul_busy_stall", 64'(stall_req_o), 64'd0);
    chk("annul_busy_valid", {62'd0, valid_o, whilo_o}, 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    count_valids(40, nv);
    chk("annul_busy_no_valid", 64'(nv), 64'd0);
    run_op(3'd1, 32'd3, 32'd4, 32'h0, 32'h0, 32'd0, 32'd12, 1'b0, "multu_after_annul");

    // Annul in DONE suppresses the pulse.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'd0; opa_i = 32'd6; opb_i = 32'd7;
    @(posedge clk);
    repeat (MUL_STAGES) @(posedge clk);
    #1 annul_i = 1'b1;
    @(negedge clk);
    chk("annul_done_out", {stall_req_o, valid_o, whilo_o, div_zero_o, hi_o, lo_o}, 68'd0);
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    count_valids(8, nv);
    chk("annul_done_no_valid", 64'(nv), 64'd0);

    // annul_i wins over start_i in IDLE.
    @(posedge clk); #1;
    start_i = 1'b1; annul_i = 1'b1; op_i = 3'd1; opa_i = 32'd2; opb_i = 32'd2;
    @(negedge clk);
    chk("annul_idle_stall", 64'(stall_req_o), 64'd0);
    repeat (3) @(posedge clk);
    #1 start_i = 1'b0; annul_i = 1'b0;
    count_valids(8, nv);
    chk("annul_idle_no_valid", 64'(nv), 64'd0);

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'd3; opa_i = 32'd77; opb_i = 32'd5;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("rst_busy_out", {stall_req_o, valid_o, whilo_o, div_zero_o, hi_o, lo_o}, 68'd0);
    count_valids(40, nv);
    chk("rst_busy_no_valid", 64'(nv), 64'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = pick(); rb = pick(); rh = $urandom; rl = $urandom;
      e = model(rop, ra, rb, rh, rl);
      run_op(rop, ra, rb, rh, rl, e[63:32], e[31:0], e[64], $sformatf("rnd%0d_op%0d", i, rop));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
